// File: rtl/proc_controller.sv
// Control unit for the 16-bit processor: owns PC and IR, fetches from the
// synchronous instruction ROM and sequences the datapath with a Moore FSM.
module proc_controller #(
  parameter int PC_W = 7,
  parameter int DA_W = 8
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [15:0]     ROM_Data,
  output logic [PC_W-1:0] PC_Out,
  output logic [15:0]     IR_Out,
  output logic [3:0]      State,
  output logic [3:0]      NextState,
  output logic [DA_W-1:0] D_Addr,
  output logic            D_Wr,
  output logic            RF_s,
  output logic [3:0]      RF_W_Addr,
  output logic            RF_W_En,
  output logic [3:0]      RF_Ra_Addr,
  output logic [3:0]      RF_Rb_Addr,
  output logic [2:0]      ALU_s0
);

  typedef enum logic [3:0] {
    ST_INIT   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_NOOP   = 4'd3,
    ST_LOAD_A = 4'd4,
    ST_LOAD_B = 4'd5,
    ST_STORE  = 4'd6,
    ST_ADD    = 4'd7,
    ST_SUB    = 4'd8,
    ST_HALT   = 4'd9
  } state_t;

  typedef struct packed {
    logic [DA_W-1:0] d_addr;
    logic            d_wr;
    logic            rf_s;
    logic [3:0]      w_addr;
    logic            w_en;
    logic [3:0]      ra_addr;
    logic [3:0]      rb_addr;
    logic [2:0]      alu;
  } ctrl_t;

  localparam logic [3:0] OP_NOOP  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_HALT  = 4'h5;

  state_t            state_r;
  state_t            next_state_s;
  logic [PC_W-1:0]   pc_r;
  logic [PC_W-1:0]   pc_next_s;
  logic [15:0]       ir_r;
  logic [15:0]       ir_next_s;
  ctrl_t             ctrl_r;
  ctrl_t             ctrl_next_s;

  // Moore output decode for a given state and instruction word.
  function automatic ctrl_t decode_ctrl(input state_t st, input logic [15:0] ir);
    ctrl_t c;
    c = '0;
    case (st)
      ST_LOAD_A, ST_LOAD_B: begin
        c.d_addr = DA_W'(ir[11:4]);
        c.w_addr = ir[3:0];
        c.rf_s   = 1'b1;
        c.w_en   = (st == ST_LOAD_B) ? 1'b1 : 1'b0;
      end
      ST_STORE: begin
        c.ra_addr = ir[11:8];
        c.d_addr  = DA_W'(ir[7:0]);
        c.d_wr    = 1'b1;
      end
      ST_ADD, ST_SUB: begin
        c.ra_addr = ir[11:8];
        c.rb_addr = ir[7:4];
        c.w_addr  = ir[3:0];
        c.rf_s    = 1'b0;
        c.w_en    = 1'b1;
        c.alu     = (st == ST_ADD) ? 3'd1 : 3'd2;
      end
      default: begin
        c = '0;
      end
    endcase
    return c;
  endfunction

  // Next-state, next-PC and next-IR logic; reset forces Init combinationally.
  always_comb begin
    next_state_s = ST_INIT;
    pc_next_s    = pc_r;
    ir_next_s    = ir_r;
    if (!Reset) begin
      next_state_s = ST_INIT;
      pc_next_s    = '0;
      ir_next_s    = '0;
    end else begin
      case (state_r)
        ST_INIT:   next_state_s = ST_FETCH;
        ST_FETCH: begin
          next_state_s = ST_DECODE;
          pc_next_s    = pc_r + PC_W'(1'b1);
          ir_next_s    = ROM_Data;
        end
        ST_DECODE: begin
          case (ir_r[15:12])
            OP_NOOP:  next_state_s = ST_NOOP;
            OP_STORE: next_state_s = ST_STORE;
            OP_LOAD:  next_state_s = ST_LOAD_A;
            OP_ADD:   next_state_s = ST_ADD;
            OP_SUB:   next_state_s = ST_SUB;
            OP_HALT:  next_state_s = ST_HALT;
            default:  next_state_s = ST_NOOP;
          endcase
        end
        ST_LOAD_A: next_state_s = ST_LOAD_B;
        ST_LOAD_B, ST_STORE, ST_ADD, ST_SUB, ST_NOOP: next_state_s = ST_FETCH;
        ST_HALT:   next_state_s = ST_HALT;
        default:   next_state_s = ST_INIT;
      endcase
    end
  end

  // Outputs are decoded from the upcoming state so they register in step with it.
  assign ctrl_next_s = decode_ctrl(next_state_s, ir_next_s);

  // State, PC, IR and registered control outputs with synchronous reset.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_r <= ST_INIT;
      pc_r    <= '0;
      ir_r    <= '0;
      ctrl_r  <= '0;
    end else begin
      state_r <= next_state_s;
      pc_r    <= pc_next_s;
      ir_r    <= ir_next_s;
      ctrl_r  <= ctrl_next_s;
    end
  end

  assign PC_Out     = pc_r;
  assign IR_Out     = ir_r;
  assign State      = state_r;
  assign NextState  = next_state_s;
  assign D_Addr     = ctrl_r.d_addr;
  assign D_Wr       = ctrl_r.d_wr;
  assign RF_s       = ctrl_r.rf_s;
  assign RF_W_Addr  = ctrl_r.w_addr;
  assign RF_W_En    = ctrl_r.w_en;
  assign RF_Ra_Addr = ctrl_r.ra_addr;
  assign RF_Rb_Addr = ctrl_r.rb_addr;
  assign ALU_s0     = ctrl_r.alu;

endmodule

// File: tb/tb_proc_controller.sv
// Directed self-checking bench for proc_controller with a synchronous ROM model.
module tb_proc_controller;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] rom_data;
  logic [6:0]  PC_Out;
  logic [15:0] IR_Out;
  logic [3:0]  State;
  logic [3:0]  NextState;
  logic [7:0]  D_Addr;
  logic        D_Wr;
  logic        RF_s;
  logic [3:0]  RF_W_Addr;
  logic        RF_W_En;
  logic [3:0]  RF_Ra_Addr;
  logic [3:0]  RF_Rb_Addr;
  logic [2:0]  ALU_s0;

  logic [15:0] rom [0:127];
  int checks = 0;
  int failures = 0;

  proc_controller #(.PC_W(7), .DA_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .ROM_Data(rom_data), .PC_Out(PC_Out),
    .IR_Out(IR_Out), .State(State), .NextState(NextState), .D_Addr(D_Addr),
    .D_Wr(D_Wr), .RF_s(RF_s), .RF_W_Addr(RF_W_Addr), .RF_W_En(RF_W_En),
    .RF_Ra_Addr(RF_Ra_Addr), .RF_Rb_Addr(RF_Rb_Addr), .ALU_s0(ALU_s0)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) rom_data <= rom[PC_Out];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    tick();
    checks++; if (State !== 4'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", State); end
    checks++; if (PC_Out !== 7'd0) begin failures++; $display("FAIL reset_pc got=%0d exp=0", PC_Out); end
    checks++; if (IR_Out !== 16'h0000) begin failures++; $display("FAIL reset_ir got=%h exp=0000", IR_Out); end
    checks++;
    if ({D_Wr, RF_W_En, ALU_s0, D_Addr, RF_W_Addr, RF_Ra_Addr, RF_Rb_Addr, RF_s} !== 32'd0) begin
      failures++; $display("FAIL reset_outputs dwr=%b wen=%b alu=%0d daddr=%h", D_Wr, RF_W_En, ALU_s0, D_Addr);
    end
    checks++; if (NextState !== 4'd0) begin failures++; $display("FAIL reset_next got=%0d exp=0", NextState); end
    tick();
    Reset = 1'b1;
    #1;
    checks++; if (NextState !== 4'd1) begin failures++; $display("FAIL init_next got=%0d exp=1", NextState); end
    tick();
    checks++; if (State !== 4'd1) begin failures++; $display("FAIL release_fetch got=%0d exp=1", State); end
  endtask

  task automatic test_load();
    tick();
    checks++; if (State !== 4'd2 || IR_Out !== 16'h21A3 || PC_Out !== 7'd1) begin
      failures++; $display("FAIL load_fetch st=%0d ir=%h pc=%0d exp 2/21a3/1", State, IR_Out, PC_Out); end
    tick();
    checks++; if (State !== 4'd4 || D_Addr !== 8'h1A || RF_W_Addr !== 4'd3 || RF_s !== 1'b1 || RF_W_En !== 1'b0) begin
      failures++; $display("FAIL load_a st=%0d da=%h w=%0d s=%b en=%b", State, D_Addr, RF_W_Addr, RF_s, RF_W_En); end
    tick();
    checks++; if (State !== 4'd5 || RF_W_En !== 1'b1 || D_Addr !== 8'h1A || RF_s !== 1'b1) begin
      failures++; $display("FAIL load_b st=%0d en=%b da=%h s=%b", State, RF_W_En, D_Addr, RF_s); end
    tick();
    checks++; if (State !== 4'd1 || RF_W_En !== 1'b0) begin
      failures++; $display("FAIL load_done st=%0d en=%b exp 1/0", State, RF_W_En); end
  endtask

  task automatic test_add_sub();
    tick();
    checks++; if (IR_Out !== 16'h3125) begin failures++; $display("FAIL add_ir got=%h exp=3125", IR_Out); end
    tick();
    checks++; if (State !== 4'd7 || RF_Ra_Addr !== 4'd1 || RF_Rb_Addr !== 4'd2 || RF_W_Addr !== 4'd5 ||
                  ALU_s0 !== 3'd1 || RF_W_En !== 1'b1 || RF_s !== 1'b0) begin
      failures++; $display("FAIL add_exec st=%0d ra=%0d rb=%0d w=%0d alu=%0d en=%b s=%b",
                           State, RF_Ra_Addr, RF_Rb_Addr, RF_W_Addr, ALU_s0, RF_W_En, RF_s); end
    tick();
    checks++; if (State !== 4'd1 || RF_W_En !== 1'b0 || ALU_s0 !== 3'd0) begin
      failures++; $display("FAIL add_done st=%0d en=%b alu=%0d", State, RF_W_En, ALU_s0); end
    tick();
    tick();
    checks++; if (State !== 4'd8 || RF_Ra_Addr !== 4'd1 || RF_Rb_Addr !== 4'd2 || RF_W_Addr !== 4'd5 ||
                  ALU_s0 !== 3'd2 || RF_W_En !== 1'b1 || RF_s !== 1'b0) begin
      failures++; $display("FAIL sub_exec st=%0d ra=%0d rb=%0d w=%0d alu=%0d en=%b",
                           State, RF_Ra_Addr, RF_Rb_Addr, RF_W_Addr, ALU_s0, RF_W_En); end
    tick();
    checks++; if (State !== 4'd1 || RF_W_En !== 1'b0) begin
      failures++; $display("FAIL sub_done st=%0d en=%b", State, RF_W_En); end
  endtask

  task automatic test_store();
    tick();
    tick();
    checks++; if (State !== 4'd6 || RF_Ra_Addr !== 4'd3 || D_Addr !== 8'h80 || D_Wr !== 1'b1 || RF_W_En !== 1'b0) begin
      failures++; $display("FAIL store_exec st=%0d ra=%0d da=%h wr=%b en=%b", State, RF_Ra_Addr, D_Addr, D_Wr, RF_W_En); end
    tick();
    checks++; if (State !== 4'd1 || D_Wr !== 1'b0) begin
      failures++; $display("FAIL store_done st=%0d wr=%b", State, D_Wr); end
  endtask

  task automatic test_illegal();
    tick();
    checks++; if (IR_Out !== 16'hF000) begin failures++; $display("FAIL illegal_ir got=%h exp=f000", IR_Out); end
    tick();
    checks++; if (State !== 4'd3 || D_Wr !== 1'b0 || RF_W_En !== 1'b0 || ALU_s0 !== 3'd0) begin
      failures++; $display("FAIL illegal_exec st=%0d wr=%b en=%b alu=%0d", State, D_Wr, RF_W_En, ALU_s0); end
    tick();
    checks++; if (State !== 4'd1) begin failures++; $display("FAIL illegal_done st=%0d exp=1", State); end
  endtask

  task automatic test_halt();
    tick();
    tick();
    checks++; if (State !== 4'd9 || PC_Out !== 7'd6) begin
      failures++; $display("FAIL halt_enter st=%0d pc=%0d exp 9/6", State, PC_Out); end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (State !== 4'd9 || PC_Out !== 7'd6 || IR_Out !== 16'h5000 || D_Wr !== 1'b0 || RF_W_En !== 1'b0) begin
        failures++; $display("FAIL halt_hold cyc=%0d st=%0d pc=%0d wr=%b en=%b", i, State, PC_Out, D_Wr, RF_W_En);
      end
    end
    Reset = 1'b0;
    #1;
    checks++; if (NextState !== 4'd0) begin failures++; $display("FAIL halt_reset_next got=%0d exp=0", NextState); end
    tick();
    checks++; if (State !== 4'd0 || PC_Out !== 7'd0 || IR_Out !== 16'h0000) begin
      failures++; $display("FAIL halt_reset st=%0d pc=%0d ir=%h", State, PC_Out, IR_Out); end
  endtask

  task automatic test_midop_reset();
    tick();
    Reset = 1'b1;
    tick();
    tick();
    tick();
    checks++; if (State !== 4'd4 || RF_W_En !== 1'b0) begin
      failures++; $display("FAIL midop_load_a st=%0d en=%b exp 4/0", State, RF_W_En); end
    Reset = 1'b0;
    tick();
    checks++; if (State !== 4'd0 || RF_W_En !== 1'b0 || D_Addr !== 8'h00 || RF_s !== 1'b0 || RF_W_Addr !== 4'd0) begin
      failures++; $display("FAIL midop_reset st=%0d en=%b da=%h s=%b", State, RF_W_En, D_Addr, RF_s); end
    Reset = 1'b1;
    tick();
    checks++; if (State !== 4'd1 || RF_W_En !== 1'b0) begin
      failures++; $display("FAIL midop_restart st=%0d en=%b", State, RF_W_En); end
  endtask

  task automatic test_pc_wrap();
    int n;
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    Reset = 1'b0;
    tick();
    tick();
    Reset = 1'b1;
    n = 0;
    while (PC_Out !== 7'd127 && n < 600) begin tick(); n++; end
    checks++; if (PC_Out !== 7'd127) begin failures++; $display("FAIL wrap_reach pc=%0d exp=127", PC_Out); end
    n = 0;
    while (PC_Out === 7'd127 && n < 10) begin tick(); n++; end
    checks++; if (PC_Out !== 7'd0 || State !== 4'd2) begin
      failures++; $display("FAIL wrap_zero pc=%0d st=%0d exp 0/2", PC_Out, State); end
    repeat (9) tick();
    checks++; if (PC_Out !== 7'd3 || State !== 4'd2) begin
      failures++; $display("FAIL wrap_continue pc=%0d st=%0d exp 3/2", PC_Out, State); end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    rom[0] = 16'h21A3;
    rom[1] = 16'h3125;
    rom[2] = 16'h4125;
    rom[3] = 16'h1380;
    rom[4] = 16'hF000;
    rom[5] = 16'h5000;
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    repeat (5) tick();

    test_reset();
    test_load();
    test_add_sub();
    test_store();
    test_illegal();
    test_halt();
    test_midop_reset();
    test_pc_wrap();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
